// File: rtl/vram_line_fetcher.sv
// Streams a frame buffer out of SDRAM in fixed-length read bursts into a pixel FIFO.
// A burst starts only when the FIFO can take it whole; pix_o shows a word one cycle after its ack.
module vram_line_fetcher #(
   parameter logic [31:0] FB_BASE      = 32'h0,
   parameter int          LINE_WORDS   = 320,
   parameter int          LINES        = 240,
   parameter int          BURST_LENGTH = 8,
   parameter int          FIFO_DEPTH   = 32
) (
   input  logic                          sdram_clk,
   input  logic                          sdram_rst,
   input  logic                          idle_i,
   output logic [31:0]                   adr_o,
   input  logic [15:0]                   dat_i,
   output logic [1:0]                    sel_o,
   output logic                          we_o,
   output logic                          acc_o,
   input  logic                          ack_i,
   input  logic                          frame_start_i,
   input  logic                          pix_rd_i,
   output logic [15:0]                   pix_o,
   output logic                          pix_valid_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o,
   output logic                          busy_o,
   output logic                          underflow_o
);

   localparam int TOTAL = LINE_WORDS * LINES;
   localparam int WCW   = $clog2(TOTAL + 1);
   localparam int BCW   = (BURST_LENGTH > 1) ? $clog2(BURST_LENGTH) : 1;
   localparam int PW    = $clog2(FIFO_DEPTH);
   localparam int LW    = PW + 1;

   typedef enum logic [2:0] {
      WAIT_IDLE,
      ARMED,
      CHECK,
      BURST,
      DRAIN,
      DONE
   } state_t;

   state_t           state_q, state_d;
   logic [31:0]      adr_q, adr_d;
   logic             acc_q, acc_d;
   logic [WCW-1:0]   word_cnt_q, word_cnt_d;
   logic [BCW-1:0]   ack_cnt_q, ack_cnt_d;
   logic             underflow_q, underflow_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]    level_q, level_d;
   logic [15:0]      mem_q [FIFO_DEPTH];

   logic             push;
   logic             pop;
   logic             flush;
   logic             last_ack;

   assign last_ack = ack_i && (ack_cnt_q == BCW'(BURST_LENGTH - 1));

   always_comb begin
      state_d    = state_q;
      adr_d      = adr_q;
      acc_d      = acc_q;
      word_cnt_d = word_cnt_q;
      ack_cnt_d  = ack_cnt_q;
      push       = 1'b0;
      flush      = 1'b0;

      case (state_q)
         WAIT_IDLE: begin
            if (idle_i) begin
               state_d = ARMED;
            end
         end
         ARMED, DONE: begin
            if (frame_start_i) begin
               flush = 1'b1;
            end
         end
         CHECK: begin
            if (frame_start_i) begin
               flush = 1'b1;
            end else if (level_q <= LW'(FIFO_DEPTH - BURST_LENGTH)) begin
               state_d   = BURST;
               acc_d     = 1'b1;
               ack_cnt_d = '0;
            end
         end
         BURST: begin
            if (ack_i) begin
               push       = 1'b1;
               ack_cnt_d  = ack_cnt_q + 1'b1;
               word_cnt_d = word_cnt_q + 1'b1;
            end
            if (last_ack) begin
               acc_d = 1'b0;
               adr_d = adr_q + 32'(2 * BURST_LENGTH);
               if (frame_start_i) begin
                  flush = 1'b1;
               end else if (word_cnt_q + 1'b1 == WCW'(TOTAL)) begin
                  state_d = DONE;
               end else begin
                  state_d = CHECK;
               end
            end else if (frame_start_i) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            // The controller cannot abandon a burst, so its remaining words are swallowed here.
            if (ack_i) begin
               ack_cnt_d = ack_cnt_q + 1'b1;
            end
            if (last_ack) begin
               acc_d = 1'b0;
               flush = 1'b1;
            end
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase

      if (flush) begin
         push       = 1'b0;
         state_d    = CHECK;
         adr_d      = FB_BASE;
         word_cnt_d = '0;
         ack_cnt_d  = '0;
      end
   end

   always_comb begin
      pop         = pix_rd_i && (level_q != '0);
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      underflow_d = underflow_q;

      // A restart empties the FIFO and forgets old underflows, overriding any pop in the same cycle.
      if (flush) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         underflow_d = 1'b0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
         endcase
         if (pix_rd_i && (level_q == '0)) begin
            underflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge sdram_clk or posedge sdram_rst) begin
      if (sdram_rst) begin
         state_q     <= WAIT_IDLE;
         adr_q       <= FB_BASE;
         acc_q       <= 1'b0;
         word_cnt_q  <= '0;
         ack_cnt_q   <= '0;
         underflow_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
      end else begin
         state_q     <= state_d;
         adr_q       <= adr_d;
         acc_q       <= acc_d;
         word_cnt_q  <= word_cnt_d;
         ack_cnt_q   <= ack_cnt_d;
         underflow_q <= underflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
      end
   end

   always_ff @(posedge sdram_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= dat_i;
      end
   end

   assign adr_o       = adr_q;
   assign acc_o       = acc_q;
   assign sel_o       = 2'b11;
   assign we_o        = 1'b0;
   assign pix_valid_o = (level_q != '0);
   assign pix_o       = pix_valid_o ? mem_q[rd_ptr_q] : 16'h0000;
   assign level_o     = level_q;
   assign busy_o      = (state_q == CHECK) || (state_q == BURST) || (state_q == DRAIN);
   assign underflow_o = underflow_q;

endmodule
